// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package rf_pkg;

    // Upper bounds that size the helper function's port/address vectors.
    localparam int MAX_AW   = 8;
    localparam int MAX_WR   = 8;
    localparam int XLEN_DEF = 32;

    typedef logic [MAX_AW-1:0]         reg_addr_t;
    typedef logic [XLEN_DEF-1:0]       xlen_t;
    typedef logic [$clog2(MAX_WR)-1:0] port_idx_t;

    typedef struct packed {
        logic      hit;
        port_idx_t idx;
    } match_t;

    // Address width for a given register count (at least one bit).
    function automatic int addr_width(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    // Pick the youngest enabled port whose address equals target.
    // order_rev=0: the highest index is youngest; order_rev=1: the lowest index is youngest.
    // A target of x0 never hits, so x0 can neither be written nor bypassed.
    function automatic match_t youngest_match(
        input logic [MAX_WR-1:0]             en,
        input logic [MAX_WR-1:0][MAX_AW-1:0] addr,
        input reg_addr_t                     target,
        input logic                          order_rev
    );
        match_t m;
        m.hit = 1'b0;
        m.idx = '0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (en[i] && (addr[i] == target) && (target != '0)) begin
                if (!m.hit || !order_rev) begin
                    m.idx = port_idx_t'(i);
                end
                m.hit = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: per-register counters, all-or-nothing issue acceptance, busy lookup.
module rf_scoreboard import rf_pkg::*; #(
    parameter int NREGS  = 32,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int CNT_W  = 2,
    parameter int AW     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR-1:0]      iss_en,
    input  logic [NUM_WR*AW-1:0]   iss_addr,
    output logic                   iss_ready,
    input  logic                   flush
);

    localparam int CMAX = (1 << CNT_W) - 1;

    logic [AW-1:0]    rd_a  [NUM_RD];
    logic [AW-1:0]    wr_a  [NUM_WR];
    logic [AW-1:0]    iss_a [NUM_WR];
    logic [CNT_W-1:0] cnt      [NREGS];
    logic [CNT_W-1:0] cnt_next [NREGS];
    int               wb_n  [NREGS];
    int               iss_n [NREGS];

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_a[i] = rd_addr[i*AW +: AW];
    end
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wr_a[p]  = wr_addr[p*AW +: AW];
        assign iss_a[p] = iss_addr[p*AW +: AW];
    end

    // Count same-cycle writebacks and issues per register; x0 and out-of-range targets are ignored.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wb_n[r]  = 0;
            iss_n[r] = 0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (r != 0 && wr_en[p] && int'(wr_a[p]) == r) begin
                    wb_n[r] = wb_n[r] + 1;
                end
                if (r != 0 && iss_en[p] && int'(iss_a[p]) == r) begin
                    iss_n[r] = iss_n[r] + 1;
                end
            end
        end
    end

    // Accept the issue group only if no target overflows after netting its writebacks.
    always_comb begin
        iss_ready = 1'b1;
        for (int r = 0; r < NREGS; r++) begin
            if (iss_n[r] > 0 && (int'(cnt[r]) + iss_n[r] - wb_n[r]) > CMAX) begin
                iss_ready = 1'b0;
            end
        end
    end

    // Next counter value: add accepted issues, subtract writebacks, clamp at zero; flush clears.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            int n;
            n = int'(cnt[r]) + (iss_ready ? iss_n[r] : 0) - wb_n[r];
            if (n < 0 || flush) begin
                n = 0;
            end
            cnt_next[r] = CNT_W'(n);
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
        end
    end

    // Busy if writes remain pending after this cycle's writebacks to the read address.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = 1'b0;
            if (rd_a[i] != '0 && int'(rd_a[i]) < NREGS) begin
                rd_busy[i] = (int'(cnt[rd_a[i]]) - wb_n[rd_a[i]]) > 0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with youngest-wins writes, read bypass,
// optional registered read stage and a pending-write scoreboard.
module regfile_mp_sb import rf_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int CNT_W  = 2,
    parameter int RD_REG = 0,
    // Derived from NREGS; not meant to be overridden.
    parameter int AW     = addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   wr_order_rev,
    input  logic [NUM_WR-1:0]      iss_en,
    input  logic [NUM_WR*AW-1:0]   iss_addr,
    output logic                   iss_ready,
    input  logic                   flush
);

    logic [MAX_WR-1:0][MAX_AW-1:0] wr_addr_x;
    logic [MAX_WR-1:0]             wr_en_x;
    logic [XLEN-1:0]               wr_d    [NUM_WR];
    logic [AW-1:0]                 rd_a    [NUM_RD];
    logic [XLEN-1:0]               regs    [NREGS];
    logic                          whit    [NREGS];
    logic [XLEN-1:0]               wval    [NREGS];
    logic [XLEN-1:0]               rd_comb [NUM_RD];
    match_t                        wm;

    assign wr_en_x = MAX_WR'(wr_en);

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign wr_d[p] = wr_data[p*XLEN +: XLEN];
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_a[i] = rd_addr[i*AW +: AW];
    end

    // Widen write addresses to the helper's fixed vector shape.
    always_comb begin
        wr_addr_x = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr_x[p] = MAX_AW'(wr_addr[p*AW +: AW]);
        end
    end

    // Per-register winning write this cycle; shared by the commit and the read bypass.
    always_comb begin
        wm = '0;
        for (int r = 0; r < NREGS; r++) begin
            wm      = youngest_match(wr_en_x, wr_addr_x, MAX_AW'(r), wr_order_rev);
            whit[r] = wm.hit;
            wval[r] = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (int'(wm.idx) == p) begin
                    wval[r] = wr_d[p];
                end
            end
        end
    end

    // Commit winning writes; x0 stays zero and out-of-range addresses never match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (whit[r]) begin
                    regs[r] <= wval[r];
                end
            end
        end
    end

    // Bypassed read: same-cycle winning write, else stored value; x0, out-of-range and reset read 0.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_comb[i] = '0;
            if (!reset && rd_a[i] != '0 && int'(rd_a[i]) < NREGS) begin
                rd_comb[i] = whit[rd_a[i]] ? wval[rd_a[i]] : regs[rd_a[i]];
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [XLEN-1:0] rd_data_p1 [NUM_RD];

        // Read stage p1: capture the bypassed value, so a same-cycle write shows up one cycle later.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < NUM_RD; i++) begin
                    rd_data_p1[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NUM_RD; i++) begin
                    rd_data_p1[i] <= rd_comb[i];
                end
            end
        end

        for (genvar i = 0; i < NUM_RD; i++) begin : g_out
            assign rd_data[i*XLEN +: XLEN] = rd_data_p1[i];
        end
    end else begin : g_rd_comb
        for (genvar i = 0; i < NUM_RD; i++) begin : g_out
            assign rd_data[i*XLEN +: XLEN] = rd_comb[i];
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .CNT_W  (CNT_W),
        .AW     (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .flush     (flush)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench: a combinational-read and a registered-read instance share stimulus
// and are compared against an array/counter reference model of the register file.
module tb_regfile_mp_sb;

    localparam int XLEN = 32, NREGS = 32, NUM_RD = 4, NUM_WR = 2, CNT_W = 2, AW = 5;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [AW-1:0]   ra [NUM_RD];
    logic [AW-1:0]   wa [NUM_WR];
    logic [XLEN-1:0] wd [NUM_WR];
    logic [AW-1:0]   ia [NUM_WR];
    logic [NUM_WR-1:0] wr_en, iss_en;
    logic wr_order_rev, flush;

    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_WR*AW-1:0]   wr_addr, iss_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic [NUM_RD*XLEN-1:0] rd_data0, rd_data1;
    logic [NUM_RD-1:0]      busy0, busy1;
    logic                   rdy0, rdy1;

    // Reference model state.
    logic [XLEN-1:0] mreg [NREGS];
    int              mcnt [NREGS];
    int              wbn  [NREGS];
    int              isn  [NREGS];
    bit              mrdy;
    logic [XLEN-1:0] exp_rd  [NUM_RD];
    logic [XLEN-1:0] prev_rd [NUM_RD];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_addr  = '0;
        wr_addr  = '0;
        iss_addr = '0;
        wr_data  = '0;
        for (int i = 0; i < NUM_RD; i++) rd_addr[i*AW +: AW] = ra[i];
        for (int p = 0; p < NUM_WR; p++) begin
            wr_addr[p*AW +: AW]     = wa[p];
            iss_addr[p*AW +: AW]    = ia[p];
            wr_data[p*XLEN +: XLEN] = wd[p];
        end
    end

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                    .CNT_W(CNT_W), .RD_REG(0)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_order_rev(wr_order_rev),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(rdy0), .flush(flush));

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                    .CNT_W(CNT_W), .RD_REG(1)) dut_r (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_order_rev(wr_order_rev),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(rdy1), .flush(flush));

    function automatic logic [XLEN-1:0] rdw(input logic [NUM_RD*XLEN-1:0] bus, input int i);
        return bus[i*XLEN +: XLEN];
    endfunction

    // Youngest writer of register r this cycle, scanning ports from youngest to oldest.
    function automatic bit find_writer(input logic [AW-1:0] r, output logic [XLEN-1:0] v);
        v = '0;
        if (r == 0) return 1'b0;
        if (!wr_order_rev) begin
            for (int p = NUM_WR - 1; p >= 0; p--)
                if (wr_en[p] && wa[p] == r) begin v = wd[p]; return 1'b1; end
        end else begin
            for (int p = 0; p < NUM_WR; p++)
                if (wr_en[p] && wa[p] == r) begin v = wd[p]; return 1'b1; end
        end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] r);
        logic [XLEN-1:0] v;
        if (reset || r == 0) return '0;
        if (find_writer(r, v)) return v;
        return mreg[r];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < NUM_RD; i++) ra[i] = '0;
        for (int p = 0; p < NUM_WR; p++) begin wa[p] = '0; wd[p] = '0; ia[p] = '0; end
        wr_en = '0; iss_en = '0; wr_order_rev = 1'b0; flush = 1'b0;
    endtask

    // Compare all outputs of both instances against the model for the current inputs.
    task automatic settle();
        #1;
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin mreg[r] = '0; mcnt[r] = 0; end
            for (int i = 0; i < NUM_RD; i++) prev_rd[i] = '0;
        end
        for (int r = 0; r < NREGS; r++) begin wbn[r] = 0; isn[r] = 0; end
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wa[p] != 0)  wbn[wa[p]]++;
            if (iss_en[p] && ia[p] != 0) isn[ia[p]]++;
        end
        mrdy = 1'b1;
        for (int r = 1; r < NREGS; r++)
            if (isn[r] > 0 && mcnt[r] + isn[r] - wbn[r] > CMAX) mrdy = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            bit eb;
            exp_rd[i] = model_read(ra[i]);
            eb = (ra[i] != 0) && (mcnt[ra[i]] - wbn[ra[i]] > 0);
            chk($sformatf("rd%0d", i), rdw(rd_data0, i), exp_rd[i]);
            chk($sformatf("rdreg%0d", i), rdw(rd_data1, i), prev_rd[i]);
            chk($sformatf("busy%0d", i), 32'(busy0[i]), 32'(eb));
            chk($sformatf("busyreg%0d", i), 32'(busy1[i]), 32'(eb));
        end
        chk("iss_ready", 32'(rdy0), 32'(mrdy));
        chk("iss_ready_reg", 32'(rdy1), 32'(mrdy));
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic adv();
        logic [XLEN-1:0] v;
        if (!reset) begin
            for (int r = 1; r < NREGS; r++)
                if (find_writer(AW'(r), v)) mreg[r] = v;
            for (int r = 0; r < NREGS; r++) begin
                int n;
                n = flush ? 0 : mcnt[r] + (mrdy ? isn[r] : 0) - wbn[r];
                mcnt[r] = (n < 0) ? 0 : n;
            end
            for (int i = 0; i < NUM_RD; i++) prev_rd[i] = exp_rd[i];
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        settle(); adv();
        reset = 1'b0;

        // Reset mid-stream with x5 written and two pending writes.
        idle(); wr_en = 2'b01; wa[0] = 5; wd[0] = 32'hDEAD_BEEF;
        iss_en = 2'b11; ia[0] = 5; ia[1] = 5; ra[0] = 5;
        settle(); adv();
        idle(); ra[0] = 5; settle();
        chk("t1_stored", rdw(rd_data0, 0), 32'hDEAD_BEEF);
        chk("t1_busy_pre", 32'(busy0[0]), 32'd1);
        adv();
        reset = 1'b1; settle();
        chk("t1_rst_data", rdw(rd_data0, 0), 32'h0);
        chk("t1_rst_busy", 32'(busy0[0]), 32'd0);
        adv();
        reset = 1'b0; settle();
        chk("t1_after_rst", rdw(rd_data0, 0), 32'h0);
        adv();

        // Same-address write conflict under both priority orders.
        for (int rev = 0; rev < 2; rev++) begin
            logic [XLEN-1:0] win;
            win = (rev == 0) ? 32'h22 : 32'h11;
            idle(); wr_en = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'h11; wd[1] = 32'h22;
            wr_order_rev = 1'(rev); ra[0] = 7;
            settle(); chk($sformatf("t2_bypass_rev%0d", rev), rdw(rd_data0, 0), win); adv();
            idle(); ra[0] = 7; settle();
            chk($sformatf("t2_stored_rev%0d", rev), rdw(rd_data0, 0), win);
            chk($sformatf("t2_regread_rev%0d", rev), rdw(rd_data1, 0), win);
            adv();
        end

        // Read-during-write: bypass now, registered stage one cycle later.
        idle(); ra[1] = 3; settle(); adv();
        idle(); wr_en = 2'b01; wa[0] = 3; wd[0] = 32'hA5A5; ra[1] = 3; settle();
        chk("t3_bypass", rdw(rd_data0, 1), 32'hA5A5);
        chk("t3_reg_old", rdw(rd_data1, 1), 32'h0);
        adv();
        idle(); ra[1] = 3; settle();
        chk("t3_reg_new", rdw(rd_data1, 1), 32'hA5A5);
        adv();

        // Counter saturation and all-or-nothing issue.
        for (int k = 0; k < 3; k++) begin
            idle(); iss_en = 2'b01; ia[0] = 9; settle(); adv();
        end
        idle(); ra[0] = 9; ra[1] = 10; iss_en = 2'b11; ia[0] = 9; ia[1] = 10; settle();
        chk("t4_ready_full", 32'(rdy0), 32'd0);
        chk("t4_busy9", 32'(busy0[0]), 32'd1);
        adv();
        idle(); ra[0] = 9; ra[1] = 10; settle();
        chk("t4_x10_not_issued", 32'(busy0[1]), 32'd0);
        adv();
        idle(); iss_en = 2'b01; ia[0] = 9; wr_en = 2'b01; wa[0] = 9; wd[0] = 32'h99; settle();
        chk("t4_ready_credit", 32'(rdy0), 32'd1);
        adv();
        for (int k = 0; k < 3; k++) begin
            idle(); wr_en = 2'b01; wa[0] = 9; wd[0] = 32'(k); ra[0] = 9; settle();
            chk($sformatf("t4_drain%0d", k), 32'(busy0[0]), (k < 2) ? 32'd1 : 32'd0);
            adv();
        end

        // Issue and writeback to the same register in one cycle.
        idle(); iss_en = 2'b01; ia[0] = 4; settle(); adv();
        idle(); iss_en = 2'b01; ia[0] = 4; wr_en = 2'b01; wa[0] = 4; ra[0] = 4; settle(); adv();
        idle(); ra[0] = 4; settle(); chk("t5_cnt_kept", 32'(busy0[0]), 32'd1); adv();
        idle(); wr_en = 2'b01; wa[0] = 4; ra[0] = 4; settle();
        chk("t5_busy_drop", 32'(busy0[0]), 32'd0);
        adv();
        idle(); ra[0] = 4; settle(); chk("t5_cnt_zero", 32'(busy0[0]), 32'd0); adv();

        // Flush with pending counts and a concurrent register write; then x0 handling.
        idle(); iss_en = 2'b11; ia[0] = 2; ia[1] = 2; settle(); adv();
        idle(); iss_en = 2'b11; ia[0] = 2; ia[1] = 8; settle(); adv();
        idle(); flush = 1'b1; wr_en = 2'b01; wa[0] = 2; wd[0] = 32'h77;
        iss_en = 2'b01; ia[0] = 8; ra[0] = 2; ra[1] = 8; settle();
        chk("t6_busy_before", 32'(busy0[0]), 32'd1);
        adv();
        idle(); ra[0] = 2; ra[1] = 8; settle();
        chk("t6_busy2", 32'(busy0[0]), 32'd0);
        chk("t6_busy8", 32'(busy0[1]), 32'd0);
        chk("t6_x2_data", rdw(rd_data0, 0), 32'h77);
        adv();
        idle(); iss_en = 2'b11; ia[0] = 0; ia[1] = 0; wr_en = 2'b01; wa[0] = 0; wd[0] = 32'hFF;
        settle();
        chk("t6_x0_data", rdw(rd_data0, 0), 32'h0);
        adv();
        idle(); settle(); chk("t6_x0_busy", 32'(busy0[0]), 32'd0); adv();

        // Randomized traffic over a small address set to provoke conflicts and saturation.
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NUM_RD; i++) ra[i] = AW'($urandom_range(0, 11));
            for (int p = 0; p < NUM_WR; p++) begin
                wa[p] = AW'($urandom_range(0, 11));
                ia[p] = AW'($urandom_range(0, 11));
                wd[p] = $urandom;
            end
            wr_en = NUM_WR'($urandom);
            iss_en = NUM_WR'($urandom);
            wr_order_rev = 1'($urandom);
            flush = ($urandom_range(0, 24) == 0);
            settle(); adv();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
